mul_share_ctrl: RTL and testbench

- Sequencer/arbiter that shares one N-bit pipelined array multiplier between two requesters.
- Arbitrates requests round-robin and latches the winner's operands.
- Drives the multiplier's shared operand bus and load strobes, waits out its pipeline, then captures the product and returns it with the requester ID over a valid/ready response channel.

---
 rtl/mul_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one pipelined multiplier between two requesters
// Optional: MUL_SHARE_CTRL_ZERO_BYPASS_EN skips the multiplier when a latched operand is zero.
module mul_share_ctrl #(
    parameter int N   = 8,
    parameter int LAT = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       req_valid,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    output logic [1:0]       req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [2*N-1:0]   resp_product,
    output logic [N-1:0]     mul_data_in,
    output logic             mul_load_a,
    output logic             mul_load_b,
    input  logic [2*N-1:0]   mul_product,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [7:0] LAT_LAST = 8'(LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic [7:0]       r_cnt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic             r_id;
    logic [2*N-1:0]   r_product;
    logic             r_resp_id;

    logic             w_grant;
    logic             w_g;
    logic [N-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_b;

    // Arbitration: pointer's requester wins if valid, otherwise the other one.
    always_comb begin
        w_grant = (r_state == S_IDLE) && (|req_valid);
        w_g     = req_valid[r_ptr] ? r_ptr : ~r_ptr;
        w_sel_a = w_g ? req_a1 : req_a0;
        w_sel_b = w_g ? req_b1 : req_b0;
    end

`ifdef MUL_SHARE_CTRL_ZERO_BYPASS_EN
    logic r_zero;
    logic w_sel_zero;
    assign w_sel_zero = (w_sel_a == '0) || (w_sel_b == '0);

    // Remember at grant time whether the multiplier can be skipped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_zero <= 1'b0;
        end else if (w_grant) begin
            r_zero <= w_sel_zero;
        end
    end
`endif

    // Next-state and strobe/bus decode; the bus is idle-zero outside the load states.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        mul_data_in = '0;
        mul_load_a  = 1'b0;
        mul_load_b  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (!clr) begin
                        req_ready[w_g] = 1'b1;
                    end
`ifdef MUL_SHARE_CTRL_ZERO_BYPASS_EN
                    w_state_nxt = w_sel_zero ? S_CAPTURE : S_LOAD_A;
`else
                    w_state_nxt = S_LOAD_A;
`endif
                end
            end
            S_LOAD_A: begin
                mul_data_in = r_a;
                mul_load_a  = 1'b1;
                w_state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                mul_data_in = r_b;
                mul_load_b  = 1'b1;
                if (r_cnt == LAT_LAST) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, arbitration pointer, operand latch, pipeline counter and result registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_cnt     <= 8'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_id      <= 1'b0;
            r_product <= '0;
            r_resp_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_id  <= w_g;
                r_ptr <= ~w_g;
            end
            if (r_state == S_LOAD_A) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_LOAD_B) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_CAPTURE) begin
`ifdef MUL_SHARE_CTRL_ZERO_BYPASS_EN
                r_product <= r_zero ? '0 : mul_product;
`else
                r_product <= mul_product;
`endif
                r_resp_id <= r_id;
            end
        end
    end

    assign resp_valid   = (r_state == S_RESP);
    assign resp_product = r_product;
    assign resp_id      = r_resp_id;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - directed and random checks of mul_share_ctrl against a behavioural model
module tb_mul_share_ctrl;

    localparam int N   = 8;
    localparam int LAT = 8;

    logic             clk = 1'b0;
    logic             clr;
    logic [1:0]       req_valid;
    logic [N-1:0]     req_a0, req_b0, req_a1, req_b1;
    logic [1:0]       req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [2*N-1:0]   resp_product;
    logic [N-1:0]     mul_data_in;
    logic             mul_load_a;
    logic             mul_load_b;
    logic [2*N-1:0]   mul_product;
    logic             busy;

    mul_share_ctrl #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product), .mul_data_in(mul_data_in),
        .mul_load_a(mul_load_a), .mul_load_b(mul_load_b), .mul_product(mul_product),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: A register, LAT-deep product pipe advancing only while load_b is high.
    logic [N-1:0]   m_a = '0;
    logic [2*N-1:0] m_pipe [LAT] = '{default: '0};
    always @(posedge clk) begin
        if (mul_load_a) m_a <= mul_data_in;
        if (mul_load_b) begin
            m_pipe[0] <= (2*N)'(m_a) * (2*N)'(mul_data_in);
            for (int i = 1; i < LAT; i++) m_pipe[i] <= m_pipe[i-1];
        end
    end
    assign mul_product = m_pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;
    bit model_ptr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rvalid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_rid"}, 64'(resp_id), 64'd0);
        chk({tag, "_prod"}, 64'(resp_product), 64'd0);
        chk({tag, "_bus"}, 64'({mul_data_in, mul_load_a, mul_load_b}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One request through grant, load phases and response; expectations come from the model.
    task automatic run_txn(input logic [1:0] valid, input logic [N-1:0] a0, input logic [N-1:0] b0,
                           input logic [N-1:0] a1, input logic [N-1:0] b1,
                           input int hold, input bit change_a0, output bit g_out);
        int  waited, t_grant, n_la, n_lb, exp_lat, exp_la, exp_lb;
        bit  g, bad_bus, bad_ready, bad_hold, got;
        logic [N-1:0]   ea, eb;
        logic [2*N-1:0] eprod;
        @(negedge clk);
        req_valid = valid; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        resp_ready = (hold == 0);
        #1;
        waited = 0;
        while (req_ready == 2'b00 && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        g = valid[model_ptr] ? model_ptr : ~model_ptr;
        chk("grant_onehot", 64'(req_ready), 64'(g ? 2'b10 : 2'b01));
        g_out = g;
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        eprod = (2*N)'(ea) * (2*N)'(eb);
        model_ptr = ~g;
        t_grant = cyc;
`ifdef MUL_SHARE_CTRL_ZERO_BYPASS_EN
        if (ea == 0 || eb == 0) begin
            exp_lat = 2; exp_la = 0; exp_lb = 0;
        end else begin
            exp_lat = LAT + 3; exp_la = 1; exp_lb = LAT;
        end
`else
        exp_lat = LAT + 3; exp_la = 1; exp_lb = LAT;
`endif
        n_la = 0; n_lb = 0; bad_bus = 0; bad_ready = 0; got = 0;
        @(negedge clk);
        req_valid = valid & ~(g ? 2'b10 : 2'b01);
        if (change_a0) req_a0 = '0;
        #1;
        for (int i = 0; i < 300; i++) begin
            if (resp_valid) begin got = 1; break; end
            if (mul_load_a) begin n_la++; if (mul_data_in !== ea) bad_bus = 1; end
            if (mul_load_b) begin n_lb++; if (mul_data_in !== eb) bad_bus = 1; end
            if (mul_load_a && mul_load_b) bad_bus = 1;
            if (!mul_load_a && !mul_load_b && mul_data_in !== '0) bad_bus = 1;
            if (req_ready !== 2'b00) bad_ready = 1;
            @(negedge clk); #1;
        end
        chk("resp_seen", 64'(got), 64'd1);
        chk("latency", 64'(cyc - t_grant), 64'(exp_lat));
        chk("load_a_cycles", 64'(n_la), 64'(exp_la));
        chk("load_b_cycles", 64'(n_lb), 64'(exp_lb));
        chk("bus_rules", 64'(bad_bus), 64'd0);
        chk("product", 64'(resp_product), 64'(eprod));
        chk("resp_id", 64'(resp_id), 64'(g));
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            if (resp_valid !== 1'b1 || resp_product !== eprod || resp_id !== g) bad_hold = 1;
            if (req_ready !== 2'b00) bad_ready = 1;
            @(negedge clk); #1;
        end
        chk("hold_stable", 64'(bad_hold), 64'd0);
        chk("no_grant_busy", 64'(bad_ready), 64'd0);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        chk("resp_released", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        bit g;
        clr = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        req_valid = 2'b11; #1;
        chk("reset_no_grant", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        @(negedge clk); clr = 1'b0;

        // Single request from requester 0.
        run_txn(2'b01, 8'd13, 8'd11, 8'd0, 8'd0, 0, 0, g);

        // Reset mid-operation, then a fresh request.
        clr = 1'b1; repeat (2) @(negedge clk); clr = 1'b0; model_ptr = 1'b0;
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 8'd9; req_b0 = 8'd9; resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        req_valid = 2'b00;
        clr = 1'b1; #1;
        check_idle_outputs("midop_reset");
        @(negedge clk); clr = 1'b0;
        run_txn(2'b01, 8'd2, 8'd3, 8'd0, 8'd0, 0, 0, g);

        // Contention from reset: 0 first, then 1, then pointer alternation.
        clr = 1'b1; @(negedge clk); clr = 1'b0; model_ptr = 1'b0;
        run_txn(2'b11, 8'd3, 8'd5, 8'd255, 8'd255, 0, 0, g);
        chk("contend_first", 64'(g), 64'd0);
        run_txn(2'b10, 8'd3, 8'd5, 8'd255, 8'd255, 0, 0, g);
        chk("contend_second", 64'(g), 64'd1);
        run_txn(2'b11, 8'd4, 8'd6, 8'd7, 8'd8, 0, 0, g);
        chk("alternate_first", 64'(g), 64'd0);
        run_txn(2'b10, 8'd4, 8'd6, 8'd7, 8'd8, 0, 0, g);

        // Back-pressure for 20 cycles.
        run_txn(2'b10, 8'd0, 8'd0, 8'd200, 8'd100, 20, 0, g);

        // Operand change right after grant is ignored.
        run_txn(2'b01, 8'd21, 8'd12, 8'd0, 8'd0, 0, 1, g);

        // Zero operand: bypass or normal path depending on build.
        run_txn(2'b10, 8'd0, 8'd0, 8'd0, 8'd77, 0, 0, g);

        // Random traffic.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            run_txn(v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), 0, g);
            req_valid = 2'b00;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
